// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and Q8.8 saturation helper for the CNN datapath.
package cnn_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int AW   = 40;

  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WLOAD,
    ST_COLLECT,
    ST_COMPUTE
  } fc_state_t;

  // Arithmetic shift drops the fraction toward -inf before clamping to the DW range.
  function automatic logic signed [DW-1:0] sat_q88(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] shifted;
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX)
      return SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN)
      return SAT_MIN[DW-1:0];
    else
      return shifted[DW-1:0];
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Single multiply-accumulate lane with bias preload and registered saturated output.
// FC_ARGMAX_EN exposes the unregistered saturated value for class tracking.
module fc_mac
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 preload,
  input  logic                 acc_en,
  input  logic                 out_en,
  input  logic signed [DW-1:0] bias,
  input  logic signed [DW-1:0] feat,
  input  logic signed [DW-1:0] weight,
`ifdef FC_ARGMAX_EN
  output logic signed [DW-1:0] sat_now,
`endif
  output logic signed [DW-1:0] result
);

  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] product;
  logic signed [AW-1:0]   product_ext;
  logic signed [AW-1:0]   bias_ext;

  assign product     = (2*DW)'(feat) * (2*DW)'(weight);
  assign product_ext = AW'(product);
  assign bias_ext    = AW'(bias) <<< FRAC;

`ifdef FC_ARGMAX_EN
  assign sat_now = sat_q88(acc);
`endif

  // Output capture and the next neuron's bias preload share one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (out_en)
        result <= sat_q88(acc);
      if (preload)
        acc <= bias_ext;
      else if (acc_en)
        acc <= acc + product_ext;
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Fully connected classifier: buffers one pooled frame and evaluates OUT_LEN neurons on one MAC.
// Optional FC_ARGMAX_EN adds class_out/class_valid running-argmax outputs.
module fc_layer
  import cnn_pkg::*;
#(
  parameter int IN_LEN  = 49,
  parameter int OUT_LEN = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_load,
  input  logic [DW-1:0] w_in,
  input  logic          pool_valid,
  input  logic [DW-1:0] pool_in,
  output logic          busy,
  output logic          fc_valid,
  output logic [3:0]    fc_idx,
  output logic [DW-1:0] fc_out,
`ifdef FC_ARGMAX_EN
  output logic [3:0]    class_out,
  output logic          class_valid,
`endif
  output logic          done_fc,
  output logic          drop_err
);

  localparam int WN   = IN_LEN * OUT_LEN;
  localparam int WTOT = WN + OUT_LEN;
  localparam int SCW  = $clog2(IN_LEN + 1);
  localparam int WCW  = $clog2(WTOT);

  fc_state_t state;

  logic [SCW-1:0] cnt;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wptr;
  logic [3:0]     neuron;
  logic           w_ok;

  logic signed [DW-1:0] feat_mem [IN_LEN];
  logic signed [DW-1:0] w_mem    [WN];
  logic signed [DW-1:0] b_mem    [OUT_LEN];

  logic                 mac_preload;
  logic                 mac_acc_en;
  logic                 mac_out_en;
  logic signed [DW-1:0] mac_bias;
  logic                 last_sample;
  logic                 feat_wr;

  // cnt doubles as the sample index while collecting and the MAC phase while computing.
  always_comb begin
    mac_preload = 1'b0;
    mac_acc_en  = 1'b0;
    mac_out_en  = 1'b0;
    mac_bias    = b_mem[0];
    last_sample = (state == ST_COLLECT) && !w_load && pool_valid &&
                  (cnt == SCW'(IN_LEN - 1));
    feat_wr     = pool_valid && !w_load &&
                  (((state == ST_IDLE) && w_ok) || (state == ST_COLLECT));
    case (state)
      ST_COLLECT: begin
        if (last_sample)
          mac_preload = 1'b1;
      end
      ST_COMPUTE: begin
        if (cnt != SCW'(IN_LEN)) begin
          mac_acc_en = 1'b1;
        end else begin
          mac_out_en = 1'b1;
          if (neuron != 4'(OUT_LEN - 1)) begin
            mac_preload = 1'b1;
            mac_bias    = b_mem[neuron + 4'd1];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_WLOAD) begin
      if (wcnt < WCW'(WN))
        w_mem[wcnt] <= w_in;
      else
        b_mem[neuron] <= w_in;
    end
    if (feat_wr)
      feat_mem[cnt] <= pool_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      wcnt     <= '0;
      wptr     <= '0;
      neuron   <= '0;
      w_ok     <= 1'b0;
      busy     <= 1'b0;
      fc_valid <= 1'b0;
      fc_idx   <= '0;
      done_fc  <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      fc_valid <= 1'b0;
      done_fc  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_load) begin
            state  <= ST_WLOAD;
            busy   <= 1'b1;
            wcnt   <= '0;
            neuron <= '0;
            cnt    <= '0;
          end else if (pool_valid && w_ok) begin
            state <= ST_COLLECT;
            cnt   <= SCW'(1);
          end
        end
        ST_WLOAD: begin
          if (pool_valid)
            drop_err <= 1'b1;
          if (wcnt >= WCW'(WN))
            neuron <= neuron + 4'd1;
          if (wcnt == WCW'(WTOT - 1)) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            w_ok   <= 1'b1;
            wcnt   <= '0;
            neuron <= '0;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        ST_COLLECT: begin
          if (w_load) begin
            state  <= ST_WLOAD;
            busy   <= 1'b1;
            wcnt   <= '0;
            neuron <= '0;
            cnt    <= '0;
          end else if (last_sample) begin
            state  <= ST_COMPUTE;
            busy   <= 1'b1;
            cnt    <= '0;
            wptr   <= '0;
            neuron <= '0;
          end else if (pool_valid) begin
            cnt <= cnt + SCW'(1);
          end
        end
        ST_COMPUTE: begin
          if (pool_valid)
            drop_err <= 1'b1;
          if (cnt != SCW'(IN_LEN)) begin
            cnt  <= cnt + SCW'(1);
            wptr <= wptr + WCW'(1);
          end else begin
            fc_valid <= 1'b1;
            fc_idx   <= neuron;
            cnt      <= '0;
            if (neuron == 4'(OUT_LEN - 1)) begin
              done_fc <= 1'b1;
              state   <= ST_IDLE;
              busy    <= 1'b0;
              neuron  <= '0;
            end else begin
              neuron <= neuron + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FC_ARGMAX_EN
  logic signed [DW-1:0] sat_now;
  logic signed [DW-1:0] max_val;
  logic [3:0]           max_idx;

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_val     <= '0;
      max_idx     <= '0;
      class_out   <= '0;
      class_valid <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (mac_out_en) begin
        if ((neuron == 4'd0) || (sat_now > max_val)) begin
          max_val <= sat_now;
          max_idx <= neuron;
        end
        if (neuron == 4'(OUT_LEN - 1)) begin
          class_valid <= 1'b1;
          class_out   <= ((neuron == 4'd0) || (sat_now > max_val)) ? neuron : max_idx;
        end
      end
    end
  end
`endif

  fc_mac u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .preload (mac_preload),
    .acc_en  (mac_acc_en),
    .out_en  (mac_out_en),
    .bias    (mac_bias),
    .feat    (feat_mem[cnt]),
    .weight  (w_mem[wptr]),
`ifdef FC_ARGMAX_EN
    .sat_now (sat_now),
`endif
    .result  (fc_out)
  );

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: expected neuron results are queued at frame capture and
// checked (value, index, done strobe, cycle) as the DUT emits them.
module tb_fc_layer;

  localparam int IN_LEN  = 49;
  localparam int OUT_LEN = 10;
  localparam int NW      = IN_LEN * OUT_LEN + OUT_LEN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        w_load = 1'b0;
  logic [15:0] w_in = '0;
  logic        pool_valid = 1'b0;
  logic [15:0] pool_in = '0;
  logic        busy, fc_valid, done_fc, drop_err;
  logic [3:0]  fc_idx;
  logic [15:0] fc_out;
`ifdef FC_ARGMAX_EN
  logic [3:0]  class_out;
  logic        class_valid;
`endif

  fc_layer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_load     (w_load),
    .w_in       (w_in),
    .pool_valid (pool_valid),
    .pool_in    (pool_in),
    .busy       (busy),
    .fc_valid   (fc_valid),
    .fc_idx     (fc_idx),
    .fc_out     (fc_out),
`ifdef FC_ARGMAX_EN
    .class_out  (class_out),
    .class_valid(class_valid),
`endif
    .done_fc    (done_fc),
    .drop_err   (drop_err)
  );

  typedef struct {
    int idx;
    int val;
    bit done;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int w_model [OUT_LEN][IN_LEN];
  int b_model [OUT_LEN];
  int feat_model [IN_LEN];
  int cyc = 0;
  int e_cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_out(int o);
    longint acc;
    acc = longint'(b_model[o]) * 256;
    for (int k = 0; k < IN_LEN; k++)
      acc += longint'(feat_model[k]) * longint'(w_model[o][k]);
    acc = acc >>> 8;
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return int'(acc);
  endfunction

  // Result monitor: pops the scoreboard on every fc_valid.
  always begin
    @(posedge clk);
    #1;
    if (fc_valid) begin
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got idx %0d val %0d, required no result",
                 fc_idx, $signed(fc_out));
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (fc_idx !== 4'(e.idx) || fc_out !== 16'(e.val) || done_fc !== e.done || cyc !== e.cyc) begin
          tests_failed++;
          $display("[TB] FAIL result: got idx %0d val %0d done %0b cyc %0d, required idx %0d val %0d done %0b cyc %0d",
                   fc_idx, $signed(fc_out), done_fc, cyc, e.idx, e.val, e.done, e.cyc);
        end
      end
    end else if (done_fc) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL done_alone: got done_fc 1 with fc_valid 0, required done only with a result");
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic load_weights(output int busy_cnt, output logic busy_end);
    busy_cnt = 0;
    @(negedge clk);
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (i > 0) @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (i < IN_LEN * OUT_LEN)
        w_in = 16'(w_model[i / IN_LEN][i % IN_LEN]);
      else
        w_in = 16'(b_model[i - IN_LEN * OUT_LEN]);
    end
    @(negedge clk);
    busy_end = busy;
  endtask

  task automatic send_frame(input bit expect_out);
    for (int i = 0; i < IN_LEN; i++) begin
      @(negedge clk);
      pool_valid = 1'b1;
      pool_in    = 16'(feat_model[i]);
    end
    @(posedge clk);
    #1;
    e_cyc = cyc;
    @(negedge clk);
    pool_valid = 1'b0;
    if (expect_out)
      for (int o = 0; o < OUT_LEN; o++)
        sb.push_back('{idx: o, val: model_out(o), done: (o == OUT_LEN - 1), cyc: e_cyc + (o + 1) * (IN_LEN + 1)});
  endtask

  task automatic wait_drain(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_weights(input int w, input int b_step);
    for (int o = 0; o < OUT_LEN; o++) begin
      b_model[o] = o * b_step;
      for (int k = 0; k < IN_LEN; k++) w_model[o][k] = w;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (fc_out !== 16'd0 || fc_idx !== 4'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got fc_out %0d fc_idx %0d, required 0 0", fc_out, fc_idx);
    end
    tests_run++;
    if ({busy, fc_valid, done_fc, drop_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got busy/valid/done/drop %b, required 0000",
               {busy, fc_valid, done_fc, drop_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reject_no_load();
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = k;
    send_frame(1'b0);
    repeat (80) @(posedge clk);
    #2;
    tests_run++;
    if (busy !== 1'b0 || drop_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_load_ignore: got busy %b drop_err %b, required 0 0", busy, drop_err);
    end
  endtask

  task automatic test_unity();
    int bc;
    logic be;
    bit ok;
    set_weights(256, 0);
    load_weights(bc, be);
    tests_run++;
    if (bc !== NW || be !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wload_duration: got busy cycles %0d end busy %b, required %0d 0", bc, be, NW);
    end
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = k;
    send_frame(1'b1);
    wait_drain(700, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL unity_timeout: got %0d pending results, required 0", sb.size());
    end
    repeat (5) @(posedge clk);
    #2;
    tests_run++;
    if (fc_out !== 16'(model_out(OUT_LEN - 1)) || fc_idx !== 4'(OUT_LEN - 1) || fc_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL output_hold: got val %0d idx %0d valid %b, required %0d %0d 0",
               $signed(fc_out), fc_idx, fc_valid, model_out(OUT_LEN - 1), OUT_LEN - 1);
    end
  endtask

  task automatic test_bias_only();
    int bc;
    logic be;
    bit ok;
    set_weights(0, 256);
    load_weights(bc, be);
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = int'($urandom_range(0, 65535)) - 32768;
    send_frame(1'b1);
    wait_drain(700, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL bias_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic test_saturation();
    int bc;
    logic be;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      set_weights((pass == 0) ? 32767 : -32768, 0);
      load_weights(bc, be);
      for (int k = 0; k < IN_LEN; k++) feat_model[k] = 32767;
      send_frame(1'b1);
      wait_drain(700, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("[TB] FAIL sat_timeout: got %0d pending results in pass %0d, required 0", sb.size(), pass);
      end
    end
  endtask

  task automatic test_drop();
    int bc;
    logic be;
    bit ok;
    set_weights(256, 0);
    for (int o = 0; o < OUT_LEN; o++)
      for (int k = 0; k < IN_LEN; k++) w_model[o][k] = int'($urandom_range(0, 1023)) - 512;
    load_weights(bc, be);
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = int'($urandom_range(0, 2000)) - 1000;
    send_frame(1'b1);
    while (cyc < e_cyc + 20) @(posedge clk);
    @(negedge clk);
    pool_valid = 1'b1;
    pool_in    = 16'h7fff;
    @(negedge clk);
    pool_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (drop_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_err_set: got %b, required 1", drop_err);
    end
    wait_drain(700, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL drop_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = int'($urandom_range(0, 255));
    send_frame(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 700 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (done_fc) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("[TB] FAIL b2b_done_timeout: got no done_fc, required done_fc");
    end
    @(negedge clk);
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = IN_LEN - k;
    send_frame(1'b1);
    wait_drain(700, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    logic be;
    bit ok;
    for (int o = 0; o < OUT_LEN; o++) begin
      b_model[o] = int'($urandom_range(0, 4095)) - 2048;
      for (int k = 0; k < IN_LEN; k++) w_model[o][k] = int'($urandom_range(0, 1023)) - 512;
    end
    load_weights(bc, be);
    for (int k = 0; k < IN_LEN; k++) feat_model[k] = int'($urandom_range(0, 511)) - 256;
    send_frame(1'b1);
    while (cyc < e_cyc + 120) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (fc_out !== 16'd0 || fc_idx !== 4'd0 || {busy, fc_valid, done_fc, drop_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got val %0d idx %0d busy/valid/done/drop %b, required 0 0 0000",
               fc_out, fc_idx, {busy, fc_valid, done_fc, drop_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b0);
    repeat (600) @(posedge clk);
    #2;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL no_reload_ignore: got busy %b, required 0", busy);
    end
    load_weights(bc, be);
    send_frame(1'b1);
    wait_drain(700, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("[TB] FAIL reload_timeout: got %0d pending results, required 0", sb.size());
    end
  endtask

`ifdef FC_ARGMAX_EN
  task automatic test_argmax();
    int bc;
    logic be;
    bit ok;
    bit seen;
    int best;
    for (int pass = 0; pass < 2; pass++) begin
      for (int o = 0; o < OUT_LEN; o++) begin
        b_model[o] = 0;
        for (int k = 0; k < IN_LEN; k++) w_model[o][k] = (pass == 0) ? o * 256 : 256;
      end
      load_weights(bc, be);
      for (int k = 0; k < IN_LEN; k++) feat_model[k] = 1;
      best = 0;
      for (int o = 1; o < OUT_LEN; o++)
        if (model_out(o) > model_out(best)) best = o;
      send_frame(1'b1);
      seen = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
        @(posedge clk);
        #2;
        if (class_valid) seen = 1'b1;
      end
      tests_run++;
      if (!seen || class_out !== 4'(best) || done_fc !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL argmax: got seen %0b class %0d done %b, required 1 %0d 1",
                 seen, class_out, done_fc, best);
      end
      wait_drain(700, ok);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reject_no_load();
    test_unity();
    test_bias_only();
    test_saturation();
    test_drop();
    test_back_to_back();
    test_reset_mid();
`ifdef FC_ARGMAX_EN
    test_argmax();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fc_layer.md
# fc_layer

Fully connected classifier stage directly downstream of `CONV_TOP`. It buffers one 7x7 pooled feature map (IN_LEN signed Q8.8 samples from `pooling_out`/`done_pooling`) and evaluates OUT_LEN neurons sequentially on a single MAC, one product per cycle. Each neuron result is emitted as a saturated Q8.8 word. Weights and biases are loaded through a pulse-then-stream port, using the same load convention as the conv stage.

## Interface
- `IN_LEN`, 49: features per frame (7x7 pooled map).
- `OUT_LEN`, 10: neurons (classes).
- `DW`, 16: data width, signed two's complement.
- `FRAC`, 8: fractional bits (Q8.8).
- `AW`, 40: accumulator width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `w_load` in 1: one-cycle pulse; starts a weight/bias stream on the next cycle.
- `w_in` in DW: weight/bias word, sampled every cycle during load.
- `pool_valid` in 1: connects to `done_pooling`; one cycle high per valid sample.
- `pool_in` in DW: connects to `pooling_out`.
- `busy` out 1: high in WLOAD and COMPUTE.
- `fc_valid` out 1: one-cycle strobe per neuron result.
- `fc_idx` out 4: neuron index of `fc_out`.
- `fc_out` out DW: saturated neuron result.
- `done_fc` out 1: one-cycle strobe with the last `fc_valid` of a frame.
- `drop_err` out 1: sticky; a sample arrived while COMPUTE or WLOAD was active.

## Operation
- States:
  - IDLE
  - WLOAD
  - COLLECT
  - COMPUTE
- Weight load:
  - `w_load` in IDLE or COLLECT enters WLOAD. Any partial frame is discarded and the sample counter is cleared.
  - The stream is IN_LEN*OUT_LEN weights, neuron-major (w[o][k], k fastest), followed by OUT_LEN biases in Q8.8.
  - After the last word, `w_ok` is set and the state moves to IDLE.
  - `w_load` in WLOAD or COMPUTE is ignored.
- Collection:
  - `pool_valid` in IDLE with `w_ok`=1 stores feat[0] and enters COLLECT.
  - `pool_valid` with `w_ok`=0 is ignored, with no error.
  - Samples are stored in arrival order. The IN_LEN-th sample enters COMPUTE.
- Compute:
  - For each neuron o, the accumulator starts at sign-extended bias[o] << FRAC.
  - It then adds feat[k]*w[o][k] for k=0..IN_LEN-1, one per cycle. Products are full 2*DW, sign-extended to AW.
  - One further cycle registers the output: `fc_out` = sat(acc >>> FRAC).
  - The shift is arithmetic (truncate toward -inf). The result clamps to [-32768, 32767].
  - After neuron OUT_LEN-1 the state moves to IDLE. Weights are retained.
- `pool_valid` in COMPUTE or WLOAD: the sample is dropped and `drop_err` is set. Only reset clears `drop_err`.
- Reset mid-operation: state goes to IDLE, all counters are cleared, and `w_ok` is cleared. Weights must be reloaded.

## Timing
- Reset values: every output is 0, including `fc_out`, `fc_idx`, `busy`, and `drop_err`.
- Edge E is the edge that captures the IN_LEN-th sample.
- Neuron o's `fc_valid` is high in the cycle after edge E+(o+1)*(IN_LEN+1).
- Defaults: first result at E+50, last at E+500. `done_fc` coincides with the last result.
- `fc_out` and `fc_idx` hold until the next `fc_valid`.
- WLOAD lasts exactly IN_LEN*OUT_LEN+OUT_LEN cycles (500 with defaults). It starts the cycle after the `w_load` pulse.
- Samples can be accepted again in the cycle after `done_fc`.

## Configuration
- `FC_ARGMAX_EN` defined:
  - Adds outputs `class_out` [3:0] and `class_valid`.
  - Tracks the running maximum `fc_out`; on a tie, the lowest index wins.
  - `class_valid` pulses with `done_fc`. `class_out` resets to 0.
- Undefined: these ports and the tracking logic are absent.

## Structure
- Package `cnn_pkg`: the `DW`, `FRAC`, `AW` constants; the state enum; and a `sat_q88` function (AW to DW shift and clamp).
- One natural sub-module: `fc_mac`, holding the multiply, accumulate, bias preload, and shift/saturate, with a registered output.
- Feature buffer and weight/bias register files stay in `fc_layer`.

## Test plan
- **Unity weights:** all weights 256, biases 0, features 0..48 -> ten results of 1176 with `fc_idx` 0..9; first at E+50, `done_fc` at E+500.
- **Bias only:** weights 0, bias[o]=o*256 -> `fc_out` = o*256 for each o.
- **Saturation:**
  - Features 32767 with weights 32767 -> 32767.
  - Features 32767 with weights -32768 -> -32768.
- **Drop and reject:**
  - A `pool_valid` pulse during COMPUTE -> `drop_err`=1 and results are unchanged.
  - `pool_valid` before any load -> ignored, `drop_err`=0.
- **Reset mid-COMPUTE:** `rst_n`=0 at E+120 -> all outputs 0. With no reload, a new frame is ignored. Reload plus a frame -> correct results.
- **`FC_ARGMAX_EN`:**
  - Weights w[o][k]=o*256, features 1 -> `class_out`=9.
  - All rows equal -> `class_out`=0.
